// File: rtl/reservoir_pkg.sv
// Shared types and width helpers for the reservoir input-weighting sequencer.
package reservoir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int prod_width(input int d, input int w);
    return d + w - 1;
  endfunction

  // A single-element reservoir still needs a 1-bit address.
  function automatic int idx_width(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shared_mult_lane.sv
// Combinational signed multiply, truncated to the product width shared by all slices.
module shared_mult_lane
  import reservoir_pkg::*;
#(
  parameter int data_width  = 3,
  parameter int weight_size = 32,
  localparam int P = prod_width(data_width, weight_size)
) (
  input  logic signed [data_width-1:0]  a,
  input  logic signed [weight_size-1:0] b,
  output logic signed [P-1:0]           product
);

  // Sign-extending both operands to P bits yields exactly the low P bits of the full product.
  assign product = P'(a) * P'(b);

endmodule

// File: rtl/reservoir_mult_sequencer.sv
// Steps one captured input vector through a single shared multiplier, one element per cycle,
// fetching each weight by address and handing the assembled product vector downstream.
module reservoir_mult_sequencer
  import reservoir_pkg::*;
#(
  parameter int data_width     = 3,
  parameter int weight_size    = 32,
  parameter int reservoir_size = 3,
  localparam int P     = prod_width(data_width, weight_size),
  localparam int IDX_W = idx_width(reservoir_size)
) (
  input  logic                                 iClk,
  input  logic                                 iRst_n,
  input  logic                                 iValid,
  output logic                                 oReady,
  input  logic [reservoir_size*data_width-1:0] iData,
  output logic [IDX_W-1:0]                     oWeightAddr,
  input  logic [weight_size-1:0]               iWeight,
  output logic                                 oValid,
  input  logic                                 iReady,
  output logic [reservoir_size*P-1:0]          oValue,
  output logic                                 oBusy
);

  state_t state, next_state;

  logic [IDX_W-1:0]                     idx;
  logic [reservoir_size*data_width-1:0] data_reg;
  logic [reservoir_size*P-1:0]          staging;
  logic [reservoir_size*P-1:0]          staging_next;
  logic signed [data_width-1:0]         cur_elem;
  logic signed [P-1:0]                  cur_prod;
  logic                                 last_elem;

  assign cur_elem  = data_reg[int'(idx)*data_width +: data_width];
  assign last_elem = (idx == IDX_W'(reservoir_size - 1));

  shared_mult_lane #(
    .data_width (data_width),
    .weight_size(weight_size)
  ) u_mult (
    .a      (cur_elem),
    .b      (iWeight),
    .product(cur_prod)
  );

  // The final element's product goes straight into oValue so the handoff is never partial.
  always_comb begin
    staging_next = staging;
    staging_next[int'(idx)*P +: P] = cur_prod;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    oReady      = 1'b0;
    oValid      = 1'b0;
    oBusy       = 1'b1;
    oWeightAddr = '0;
    unique case (state)
      IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) next_state = RUN;
      end
      RUN: begin
        oWeightAddr = idx;
        if (last_elem) next_state = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_reg <= '0;
      staging  <= '0;
      oValue   <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            data_reg <= iData;
            idx      <= '0;
          end
        end
        RUN: begin
          staging <= staging_next;
          if (last_elem) begin
            oValue <= staging_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reservoir_mult_sequencer.sv
// Directed self-checking bench for reservoir_mult_sequencer with N=3, D=3, W=32 (P=34).
module tb_reservoir_mult_sequencer;

  localparam int D = 3;
  localparam int W = 32;
  localparam int N = 3;
  localparam int P = D + W - 1;

  logic           iClk = 1'b0;
  logic           iRst_n;
  logic           iValid;
  logic           oReady;
  logic [N*D-1:0] iData;
  logic [1:0]     oWeightAddr;
  logic [W-1:0]   iWeight;
  logic           oValid;
  logic           iReady;
  logic [N*P-1:0] oValue;
  logic           oBusy;

  logic [W-1:0] weight_mem [4];

  int n_checks = 0;
  int n_fail   = 0;

  reservoir_mult_sequencer #(
    .data_width    (D),
    .weight_size   (W),
    .reservoir_size(N)
  ) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iData      (iData),
    .oWeightAddr(oWeightAddr),
    .iWeight    (iWeight),
    .oValid     (oValid),
    .iReady     (iReady),
    .oValue     (oValue),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  // Combinational weight memory model.
  assign iWeight = weight_mem[oWeightAddr];

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic set_weights(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2);
    weight_mem[0] = w0;
    weight_mem[1] = w1;
    weight_mem[2] = w2;
    weight_mem[3] = '0;
  endtask

  // Hands one vector over from IDLE, waits for DONE, checks latency and result, releases it.
  task automatic applyStimulus(input string tag, input logic [N*D-1:0] data,
                               input logic [N*P-1:0] expected);
    int lat;
    iData  = data;
    iValid = 1'b1;
    checkOutput({tag, "_ready"}, oReady, 1'b1);
    tick();
    iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, N);
    checkOutput({tag, "_value"}, oValue, expected);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkOutput({tag, "_released"}, oValid, 1'b0);
  endtask

  logic [N*D-1:0] tp_vec [3];
  logic [N*P-1:0] tp_exp [3];
  int             accept_cyc [3];
  int             n_acc;
  int             n_res;
  logic           will_accept;

  initial begin
    iRst_n = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iData  = '0;
    set_weights(32'd5, -32'sd2, 32'd7);

    #3;
    checkOutput("rst_ready", oReady, 1'b1);
    checkOutput("rst_valid", oValid, 1'b0);
    checkOutput("rst_busy", oBusy, 1'b0);
    checkOutput("rst_addr", oWeightAddr, 2'd0);
    checkOutput("rst_value", oValue, '0);
    #4;
    iRst_n = 1'b1;
    tick();

    // Basic vector {1,-1,3} against weights {5,-2,7}, watching the address sequence.
    iData  = {3'd3, 3'b111, 3'd1};
    iValid = 1'b1;
    checkOutput("t1_idle_addr", oWeightAddr, 2'd0);
    tick();
    iValid = 1'b0;
    checkOutput("t1_addr0", oWeightAddr, 2'd0);
    checkOutput("t1_busy", oBusy, 1'b1);
    checkOutput("t1_not_ready", oReady, 1'b0);
    checkOutput("t1_no_valid0", oValid, 1'b0);
    tick();
    checkOutput("t1_addr1", oWeightAddr, 2'd1);
    checkOutput("t1_no_valid1", oValid, 1'b0);
    tick();
    checkOutput("t1_addr2", oWeightAddr, 2'd2);
    checkOutput("t1_no_valid2", oValid, 1'b0);
    tick();
    checkOutput("t1_valid", oValid, 1'b1);
    checkOutput("t1_done_addr", oWeightAddr, 2'd0);
    checkOutput("t1_value", oValue, {34'd21, 34'd2, 34'd5});

    // Downstream stalls for 5 cycles; a stray iValid pulse must not be taken.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        iValid = 1'b1;
        iData  = {3'd1, 3'd1, 3'd1};
      end else begin
        iValid = 1'b0;
      end
      tick();
      checkOutput("t2_hold_valid", oValid, 1'b1);
      checkOutput("t2_hold_value", oValue, {34'd21, 34'd2, 34'd5});
      checkOutput("t2_hold_ready", oReady, 1'b0);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkOutput("t2_idle_valid", oValid, 1'b0);
    checkOutput("t2_idle_ready", oReady, 1'b1);
    checkOutput("t2_value_kept", oValue, {34'd21, 34'd2, 34'd5});
    tick();
    checkOutput("t2_not_accepted", oBusy, 1'b0);

    // Most negative data times most negative weight wraps in P bits.
    set_weights(32'h8000_0000, 32'd1, 32'd1);
    applyStimulus("t3_wrap", {3'd1, 3'd1, 3'b100}, {34'd1, 34'd1, 34'h2_0000_0000});

    // Asynchronous reset while idx=1 discards the vector immediately.
    set_weights(32'd5, -32'sd2, 32'd7);
    iData  = {3'd3, 3'b111, 3'd1};
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    checkOutput("t4_mid_addr", oWeightAddr, 2'd1);
    #1;
    iRst_n = 1'b0;
    #1;
    checkOutput("t4_rst_valid", oValid, 1'b0);
    checkOutput("t4_rst_value", oValue, '0);
    checkOutput("t4_rst_ready", oReady, 1'b1);
    checkOutput("t4_rst_addr", oWeightAddr, 2'd0);
    #1;
    iRst_n = 1'b1;
    tick();
    set_weights(32'd1, 32'd1, 32'd1);
    applyStimulus("t4_after", {3'd2, 3'd2, 3'd2}, {34'd2, 34'd2, 34'd2});

    // Back-to-back vectors with iValid and iReady held high.
    set_weights(32'd5, -32'sd2, 32'd7);
    tp_vec[0] = {3'd3, 3'd2, 3'd1};
    tp_exp[0] = {34'd21, -34'sd4, 34'd5};
    tp_vec[1] = {3'b101, 3'b110, 3'b111};
    tp_exp[1] = {-34'sd21, 34'd4, -34'sd5};
    tp_vec[2] = {3'b100, 3'd0, 3'd3};
    tp_exp[2] = {-34'sd28, 34'd0, 34'd15};
    n_acc = 0;
    n_res = 0;
    iReady = 1'b1;
    iData  = tp_vec[0];
    iValid = 1'b1;
    for (int cyc = 0; cyc < 60 && n_res < 3; cyc++) begin
      will_accept = oReady && iValid;
      if (oValid) begin
        checkOutput("t5_value", oValue, tp_exp[n_res]);
        n_res++;
      end
      tick();
      if (will_accept && n_acc < 3) begin
        accept_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) iData = tp_vec[n_acc];
        else iValid = 1'b0;
      end
    end
    iValid = 1'b0;
    iReady = 1'b0;
    checkOutput("t5_results", n_res, 3);
    checkOutput("t5_accepts", n_acc, 3);
    if (n_acc == 3) begin
      checkOutput("t5_gap01", accept_cyc[1] - accept_cyc[0], 5);
      checkOutput("t5_gap12", accept_cyc[2] - accept_cyc[1], 5);
    end
    tick();

    // Input bus churn during RUN must not leak into the result.
    iData  = {3'd3, 3'b111, 3'd1};
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      iData = N*D'($urandom);
      tick();
    end
    checkOutput("t6_valid", oValid, 1'b1);
    checkOutput("t6_value", oValue, {34'd21, 34'd2, 34'd5});
    iReady = 1'b1;
    tick();
    iReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
